// File: rtl/vec_reg_unloader_pkg.sv
// Shared types and default sizes for the vector register unloader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vec_reg_unloader_pkg;

    localparam int VEC_BITS  = 8;   // element width
    localparam int VEC_N     = 4;   // max elements per register, matches the bank
    localparam int VEC_LEN_W = 8;   // length field width, matches bank in_len/out_len
    localparam int VEC_SEL_W = 4;   // register select width (16 registers)

    typedef logic [VEC_BITS-1:0] vec_elem_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } unload_state_t;

endpackage

// File: rtl/vec_reg_unloader.sv
// Reads one bank register on command, snapshots it and streams its elements with last marking.
// Latency: command accepted in cycle C, bank read in C+1, first beat valid in C+2, then 1 beat/cycle.
// Backpressure: m_ready low holds data/last/valid stable; cmd_ready low while busy, commands dropped.
module vec_reg_unloader
    import vec_reg_unloader_pkg::*;
#(
    parameter int BITS  = VEC_BITS,
    parameter int N     = VEC_N,
    parameter int LEN_W = VEC_LEN_W,
    parameter int SEL_W = VEC_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             cmd_ready,
    output logic [SEL_W-1:0] rd_sel,
    output logic             rd_en,
    input  logic [BITS-1:0]  rd_data [N-1:0],
    input  logic [LEN_W-1:0] rd_len,
    output logic [BITS-1:0]  m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             done,
    output logic [LEN_W-1:0] done_cnt,
    output logic             len_err
);

    // One extra index bit so a count of exactly N never wraps to zero.
    localparam int IDX_W = $clog2(N) + 1;
    localparam int AW    = $clog2(N);

    unload_state_t    state;
    logic [BITS-1:0]  snap [N-1:0];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] idx_nxt;
    logic             err;

    logic             fetch_err;
    logic [IDX_W-1:0] fetch_len;

    // Bank length above N is clamped; the compare is done at full length width.
    assign fetch_err = rd_len > LEN_W'(N);
    assign fetch_len = fetch_err ? IDX_W'(N) : rd_len[IDX_W-1:0];
    assign idx_nxt   = idx + IDX_W'(1);

    // Unload FSM: accept command, read/snapshot the register, stream the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rd_en     <= 1'b0;
            rd_sel    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            done      <= 1'b0;
            done_cnt  <= '0;
            len_err   <= 1'b0;
            idx       <= '0;
            len       <= '0;
            err       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                snap[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rd_sel    <= cmd_sel;
                        rd_en     <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // Bank read port is combinational, so rd_data/rd_len are valid now.
                    rd_en <= 1'b0;
                    idx   <= '0;
                    len   <= fetch_len;
                    err   <= fetch_err;
                    for (int i = 0; i < N; i++) begin
                        snap[i] <= rd_data[i];
                    end
                    if (fetch_len == '0) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                        done_cnt  <= '0;
                        len_err   <= fetch_err;
                    end else begin
                        // Snapshot lands this edge too, so beat 0 comes straight from the bank.
                        state   <= STREAM;
                        m_valid <= 1'b1;
                        m_data  <= rd_data[0];
                        m_last  <= (fetch_len == IDX_W'(1));
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state     <= IDLE;
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            m_data    <= '0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                            done_cnt  <= LEN_W'(len);
                            len_err   <= err;
                        end else begin
                            idx    <= idx_nxt;
                            m_data <= snap[idx_nxt[AW-1:0]];
                            m_last <= (idx_nxt == (len - IDX_W'(1)));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_reg_unloader.sv
module tb_vec_reg_unloader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_sel;
    logic       cmd_ready;
    logic [3:0] rd_sel;
    logic       rd_en;
    logic [7:0] rd_data [3:0];
    logic [7:0] rd_len;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       done;
    logic [7:0] done_cnt;
    logic       len_err;

    // Behavioural register bank: element i of a register is the i-th beat.
    logic [7:0] bank_data [16][4];
    logic [7:0] bank_len  [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_reg_unloader #(.BITS(8), .N(4), .LEN_W(8), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_sel   (cmd_sel),
        .cmd_ready (cmd_ready),
        .rd_sel    (rd_sel),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_len    (rd_len),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .done      (done),
        .done_cnt  (done_cnt),
        .len_err   (len_err)
    );

    // Combinational bank read port
    always_comb begin
        for (int i = 0; i < 4; i++) rd_data[i] = bank_data[rd_sel][i];
        rd_len = bank_len[rd_sel];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issue one unload of register sel and score it against the bank contents at command time.
    // mode 0: m_ready always 1; mode 1: ready pattern 1,0,0,1,0,0...; mode 2: random ready.
    task automatic unload(input int sel, input int mode, input bit midwr, input bit midcmd);
        logic [7:0] exp_q [$];
        int         n;
        bit         exp_err;
        int         cyc;
        int         got;
        bit         fin;
        bit         seen_valid;
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;

        exp_err = (bank_len[sel] > 8'd4);
        n = exp_err ? 4 : int'(bank_len[sel]);
        for (int i = 0; i < n; i++) exp_q.push_back(bank_data[sel][i]);

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_sel   = 4'(sel);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        check("rd_en_fetch", rd_en, 1);
        check("rd_sel_fetch", rd_sel, sel);
        check("cmd_ready_busy", cmd_ready, 0);
        check("no_valid_fetch", m_valid, 0);

        got = 0;
        fin = 0;
        seen_valid = 0;
        prev_stall = 0;
        prev_d = '0;
        prev_l = 1'b0;
        while (!fin && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (midcmd && cyc == 3) begin
                check("cmd_ready_mid", cmd_ready, 0);
                cmd_valid = 1'b1;
                cmd_sel   = 4'(sel ^ 1);
            end else begin
                cmd_valid = 1'b0;
            end
            if (midwr && cyc == 3) begin
                for (int i = 0; i < 4; i++) bank_data[sel][i] = 8'h00;
            end
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_d);
                check("hold_last", m_last, prev_l);
            end
            if (m_valid && !seen_valid) begin
                seen_valid = 1;
                if (mode == 0) check("first_beat_latency", cyc, 2);
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 2);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid && m_ready) begin
                check("beat_data", m_data, (got < n) ? exp_q[got] : 8'hxx);
                check("beat_last", m_last, (got == n - 1));
                got++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (done) begin
                fin = 1;
                check("done_cnt", done_cnt, n);
                check("len_err", len_err, exp_err);
                check("beat_count", got, n);
                check("valid_at_done", m_valid, 0);
                check("any_beat", seen_valid, (n > 0));
                if (mode == 0) check("done_latency", cyc, n + 2);
            end
        end
        check("done_seen", fin, 1);
        cmd_valid = 1'b0;
        m_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("rd_en_after", rd_en, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        m_ready   = 1'b0;
        for (int r = 0; r < 16; r++) begin
            bank_len[r] = 8'd0;
            for (int i = 0; i < 4; i++) bank_data[r][i] = 8'h00;
        end
        bank_data[0][0] = 8'h0F; bank_data[0][1] = 8'h3C; bank_len[0] = 8'd2;
        bank_data[1][0] = 8'hFF; bank_data[1][1] = 8'h7E; bank_data[1][2] = 8'h7D; bank_len[1] = 8'd3;
        bank_len[2] = 8'd0;
        bank_data[3][0] = 8'h0F; bank_data[3][1] = 8'h3C; bank_data[3][2] = 8'h01;
        bank_data[3][3] = 8'h02; bank_len[3] = 8'd6;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_sel", rd_sel, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_done", done, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_len_err", len_err, 0);

        // Full-rate stream, stalled stream, empty register, over-length register
        unload(1, 0, 0, 0);
        unload(1, 1, 0, 0);
        unload(2, 0, 0, 0);
        unload(3, 0, 0, 0);
        // Bank overwrite and a stray command during the stream
        unload(1, 0, 1, 1);

        // Reset after the second beat discards the stream without done
        bank_data[1][0] = 8'hFF; bank_data[1][1] = 8'h7E; bank_data[1][2] = 8'h7D;
        cmd_valid = 1'b1;
        cmd_sel   = 4'd1;
        m_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_test_beat1", m_data, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        check("rst_test_beat2", m_data, 8'h7E);
        check("rst_test_valid2", m_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_valid", m_valid, 0);
        check("rst_async_done", done, 0);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_done", done, 0);
        check("rst_release_valid", m_valid, 0);
        unload(0, 0, 0, 0);

        // Randomised registers, lengths and backpressure
        for (int t = 0; t < 12; t++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            bank_len[sel] = 8'($urandom_range(0, 6));
            for (int i = 0; i < 4; i++) bank_data[sel][i] = 8'($urandom_range(0, 255));
            unload(sel, (t % 3 == 0) ? 1 : 2, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
